alu_issue_stage: RTL and testbench

- Sequential wrapper that sits directly upstream and downstream of the combinational ALU.
- Accepts operation commands over a valid/ready handshake and holds each one in an operand register. It drives the ALU's SEL/A/B from that register and captures the ALU's result and carry into a result FIFO.
- Results are returned in order over a second valid/ready handshake.
- Optional accumulate mode substitutes the previous result for operand A, so operation chains need no software round-trip.

---
 rtl/alu_issue_stage_if.sv | 32 +++
 rtl/alu_issue_stage.sv | 131 +++++++++++++
 tb/tb_alu_issue_stage.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake and ALU-side signal bundle for alu_issue_stage.
// master = command producer / result consumer / ALU; slave = the issue stage.
interface alu_issue_stage_if #(
    parameter int WIDTH = 4
);
    logic             IN_VALID;
    logic             IN_READY;
    logic [2:0]       IN_SEL;
    logic [WIDTH-1:0] IN_A;
    logic [WIDTH-1:0] IN_B;
    logic             IN_ACC;
    logic [2:0]       ALU_SEL;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [WIDTH:0]   ALU_O;
    logic             ALU_CARRY;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_CARRY;
    logic [WIDTH-1:0] ACC;

    modport master (
        output IN_VALID, IN_SEL, IN_A, IN_B, IN_ACC, OUT_READY, ALU_O, ALU_CARRY,
        input  IN_READY, ALU_SEL, ALU_A, ALU_B, OUT_VALID, OUT_DATA, OUT_CARRY, ACC
    );

    modport slave (
        input  IN_VALID, IN_SEL, IN_A, IN_B, IN_ACC, OUT_READY, ALU_O, ALU_CARRY,
        output IN_READY, ALU_SEL, ALU_A, ALU_B, OUT_VALID, OUT_DATA, OUT_CARRY, ACC
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand register + accumulator + show-ahead result FIFO wrapped around a
// combinational ALU; commands in and results out over valid/ready.
module alu_issue_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    alu_issue_stage_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic             carry;
        logic [WIDTH-1:0] data;
    } result_t;

    logic             op_valid_q, op_valid_d;
    logic [2:0]       op_sel_q, op_sel_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             op_acc_q, op_acc_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    result_t          hold_q, hold_d;
    result_t          fifo_mem [DEPTH];

    logic    not_full, push, pop, in_ready, accept;
    result_t alu_res, head;
    logic    alu_o_msb_unused;

    assign alu_o_msb_unused = bus.ALU_O[WIDTH];

    // NOTE: every variable gets a default at the top of the block, so no
    // path through the branches can leave it unassigned and infer a latch.
    always_comb begin
        not_full = count_q < CNT_W'(DEPTH);
        push     = op_valid_q && not_full;
        pop      = (count_q != '0) && bus.OUT_READY;
        in_ready = !op_valid_q || not_full;
        accept   = bus.IN_VALID && in_ready;
        alu_res  = '{carry: bus.ALU_CARRY, data: bus.ALU_O[WIDTH-1:0]};
        head     = fifo_mem[rd_ptr_q];

        op_valid_d = op_valid_q;
        op_sel_d   = op_sel_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_acc_d   = op_acc_q;
        acc_d      = acc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        hold_d     = hold_q;

        // A new command overrides the consume of the old one in the same cycle.
        if (accept) begin
            op_valid_d = 1'b1;
            op_sel_d   = bus.IN_SEL;
            op_a_d     = bus.IN_A;
            op_b_d     = bus.IN_B;
            op_acc_d   = bus.IN_ACC;
        end else if (push) begin
            op_valid_d = 1'b0;
        end

        if (push) begin
            acc_d    = alu_res.data;
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            hold_d   = head;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_valid_q <= 1'b0;
            op_sel_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_acc_q   <= 1'b0;
            acc_q      <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            hold_q     <= '0;
        end else begin
            op_valid_q <= op_valid_d;
            op_sel_q   <= op_sel_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_acc_q   <= op_acc_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            hold_q     <= hold_d;
        end
    end

    // NOTE: the storage array is not reset; an entry is only read once count
    // says it was written, and the empty-FIFO output comes from hold_q.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= alu_res;
        end
    end

    assign bus.IN_READY  = in_ready;
    assign bus.ALU_SEL   = op_sel_q;
    assign bus.ALU_A     = op_acc_q ? acc_q : op_a_q;
    assign bus.ALU_B     = op_b_q;
    assign bus.OUT_VALID = count_q != '0;
    assign bus.OUT_DATA  = (count_q != '0) ? head.data  : hold_q.data;
    assign bus.OUT_CARRY = (count_q != '0) ? head.carry : hold_q.carry;
    assign bus.ACC       = acc_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage with a behavioural ALU attached;
// expectations come from an in-order command model with its own accumulator.
module tb_alu_issue_stage;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [WIDTH:0] sb_q [$];
    logic [WIDTH-1:0] m_acc = '0;
    logic rand_done;

    alu_issue_stage_if #(.WIDTH(WIDTH)) bus ();

    alu_issue_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic logic [WIDTH:0] alu_ref(input logic [2:0] sel,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (sel)
            3'b000:  r = {1'b0, a & b};
            3'b001:  r = {1'b0, a | b};
            3'b010:  r = {1'b0, a ^ b};
            3'b011:  r = {1'b0, a} + {1'b0, b};
            default: r = {(a < b), a - b};
        endcase
        return r;
    endfunction

    // Behavioural ALU; O's top bit is deliberately the inverse of carry.
    always_comb begin
        logic [WIDTH:0] r;
        r = alu_ref(bus.ALU_SEL, bus.ALU_A, bus.ALU_B);
        bus.ALU_CARRY = r[WIDTH];
        bus.ALU_O     = {~r[WIDTH], r[WIDTH-1:0]};
    end

    // Accepts feed the model; pops are compared against it.
    always @(negedge CLK) begin
        if (!RST) begin
            if (bus.IN_VALID && bus.IN_READY) begin
                logic [WIDTH:0] e;
                e = alu_ref(bus.IN_SEL, bus.IN_ACC ? m_acc : bus.IN_A, bus.IN_B);
                m_acc = e[WIDTH-1:0];
                sb_q.push_back(e);
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got carry=%0b data=%h, expected no result",
                             bus.OUT_CARRY, bus.OUT_DATA);
                end else begin
                    logic [WIDTH:0] e;
                    e = sb_q.pop_front();
                    if ({bus.OUT_CARRY, bus.OUT_DATA} !== e) begin
                        errors++;
                        $display("FAIL sb_result: got carry=%0b data=%h, expected carry=%0b data=%h",
                                 bus.OUT_CARRY, bus.OUT_DATA, e[WIDTH], e[WIDTH-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input logic [2:0] sel, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic acc);
        bus.IN_SEL = sel;
        bus.IN_A   = a;
        bus.IN_B   = b;
        bus.IN_ACC = acc;
    endtask

    // Presents a command and returns 1ns after the edge that accepts it.
    task automatic send(input logic [2:0] sel, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic acc);
        int n = 0;
        set_op(sel, a, b, acc);
        bus.IN_VALID = 1'b1;
        @(negedge CLK);
        while (!bus.IN_READY && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (!bus.IN_READY) begin
            errors++;
            checks++;
            $display("FAIL send_timeout: IN_READY=%0b after %0d cycles, expected 1", bus.IN_READY, n);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || bus.OUT_VALID) && n < 300) begin
            @(posedge CLK);
            #1;
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || bus.OUT_VALID) begin
            errors++;
            $display("FAIL drain: pending=%0d OUT_VALID=%0b, expected 0 and 0", sb_q.size(), bus.OUT_VALID);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.IN_READY, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_CARRY, bus.ACC} !== {1'b1, 1'b0, 4'h0, 1'b0, 4'h0}) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%0b vld=%0b data=%h carry=%0b acc=%h, expected 1 0 0 0 0",
                     bus.IN_READY, bus.OUT_VALID, bus.OUT_DATA, bus.OUT_CARRY, bus.ACC);
        end
        checks++;
        if ({bus.ALU_SEL, bus.ALU_A, bus.ALU_B} !== '0) begin
            errors++;
            $display("FAIL reset_alu: sel=%0d a=%h b=%h, expected 0 0 0", bus.ALU_SEL, bus.ALU_A, bus.ALU_B);
        end
    endtask

    task automatic test_basic_ops();
        bus.OUT_READY = 1'b1;
        send(3'b011, 4'h9, 4'h8, 1'b0);
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL add_latency_early: OUT_VALID=%0b, expected 0", bus.OUT_VALID);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA, bus.ACC} !== {1'b1, 1'b1, 4'h1, 4'h1}) begin
            errors++;
            $display("FAIL add_result: vld=%0b carry=%0b data=%h acc=%h, expected 1 1 1 1",
                     bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA, bus.ACC);
        end
        drain();
        send(3'b100, 4'h3, 4'h5, 1'b0);
        send(3'b010, 4'hA, 4'h6, 1'b0);
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA} !== {1'b1, 1'b1, 4'hE}) begin
            errors++;
            $display("FAIL sub_borrow: vld=%0b carry=%0b data=%h, expected 1 1 e",
                     bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA);
        end
        drain();
        checks++;
        if ({bus.OUT_CARRY, bus.OUT_DATA} !== {1'b0, 4'hC}) begin
            errors++;
            $display("FAIL empty_hold: carry=%0b data=%h, expected 0 c", bus.OUT_CARRY, bus.OUT_DATA);
        end
    endtask

    task automatic test_back_to_back();
        bus.OUT_READY = 1'b1;
        send(3'b011, 4'h2, 4'h3, 1'b0);
        send(3'b011, 4'hF, 4'h4, 1'b1);
        send(3'b100, 4'hF, 4'h1, 1'b1);
        bus.IN_VALID = 1'b0;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_DATA} !== {1'b1, 4'h9}) begin
            errors++;
            $display("FAIL chain_second: vld=%0b data=%h, expected 1 9", bus.OUT_VALID, bus.OUT_DATA);
        end
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_DATA, bus.ACC} !== {1'b1, 4'h8, 4'h8}) begin
            errors++;
            $display("FAIL chain_third: vld=%0b data=%h acc=%h, expected 1 8 8",
                     bus.OUT_VALID, bus.OUT_DATA, bus.ACC);
        end
        drain();
    endtask

    task automatic test_backpressure();
        int accepts = 0;
        int k = 1;
        bus.OUT_READY = 1'b0;
        set_op(3'b001, 4'(k), 4'h0, 1'b0);
        bus.IN_VALID = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            if (bus.IN_READY && k <= 6) begin
                accepts++;
                @(posedge CLK);
                #1;
                k++;
                if (k <= 6) set_op(3'b001, 4'(k), 4'h0, 1'b0);
                else bus.IN_VALID = 1'b0;
            end else begin
                @(posedge CLK);
                #1;
            end
        end
        checks++;
        if (accepts !== 5) begin
            errors++;
            $display("FAIL bp_accepts: got %0d accepts, expected 5", accepts);
        end
        checks++;
        if ({bus.IN_READY, bus.OUT_VALID} !== 2'b01) begin
            errors++;
            $display("FAIL bp_full: rdy=%0b vld=%0b, expected 0 1", bus.IN_READY, bus.OUT_VALID);
        end
        bus.OUT_READY = 1'b1;
        for (int c = 0; c < 20 && k <= 6; c++) begin
            @(negedge CLK);
            if (bus.IN_READY) begin
                accepts++;
                k++;
            end
            @(posedge CLK);
            #1;
        end
        bus.IN_VALID = 1'b0;
        checks++;
        if (accepts !== 6) begin
            errors++;
            $display("FAIL bp_release: got %0d accepts, expected 6", accepts);
        end
        drain();
    endtask

    task automatic test_random_traffic();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    send(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                         4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
                end
                bus.IN_VALID = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge CLK);
                    #1;
                    bus.OUT_READY = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.OUT_READY = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid_op();
        bus.OUT_READY = 1'b0;
        for (int k = 1; k <= 4; k++) send(3'b011, 4'(k), 4'(k), 1'b0);
        bus.IN_VALID = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({bus.OUT_VALID, bus.IN_READY, bus.ACC, bus.OUT_DATA} !== {1'b0, 1'b1, 4'h0, 4'h0}) begin
            errors++;
            $display("FAIL async_reset: vld=%0b rdy=%0b acc=%h data=%h, expected 0 1 0 0",
                     bus.OUT_VALID, bus.IN_READY, bus.ACC, bus.OUT_DATA);
        end
        sb_q.delete();
        m_acc = '0;
        @(posedge CLK);
        #2;
        RST = 1'b0;
        bus.OUT_READY = 1'b1;
        send(3'b011, 4'h3, 4'h7, 1'b1);
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if ({bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA} !== {1'b1, 1'b0, 4'h7}) begin
            errors++;
            $display("FAIL post_reset_acc: vld=%0b carry=%0b data=%h, expected 1 0 7",
                     bus.OUT_VALID, bus.OUT_CARRY, bus.OUT_DATA);
        end
        drain();
    endtask

    initial begin
        bus.IN_VALID  = 1'b0;
        bus.OUT_READY = 1'b0;
        set_op(3'b000, 4'h0, 4'h0, 1'b0);
        repeat (2) @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        test_reset();
        test_basic_ops();
        test_back_to_back();
        test_backpressure();
        test_random_traffic();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
